fridge_zone_ctrl: RTL

Clocked, parametrised successor to the two-compartment combinational fridge controller. Stores a temperature setpoint and a capacity setting for each of `NUM_ZONES` compartments, and runs per-zone cooling hysteresis. Drives one shared compressor through a minimum-off-time lockout FSM, raises a door-open alarm after a timeout, and holds an optional ice-maker latch. It sits between the front-panel write bus and the compressor, ice and alarm drivers.

---
 rtl/fridge_pkg.sv | 23 ++
 rtl/fridge_zone.sv | 107 ++++++++++
 rtl/fridge_zone_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fridge_pkg.sv
// Shared field codes, capacity unit and compressor state encoding for the
// multi-zone fridge controller.
package fridge_pkg;

    localparam logic [1:0] FIELD_TEMP = 2'd0;
    localparam logic [1:0] FIELD_CAP  = 2'd1;
    localparam logic [1:0] FIELD_ICE  = 2'd2;
    localparam logic [1:0] FIELD_RSVD = 2'd3;

    localparam logic [7:0] CAP_UNIT = 8'd25;

    typedef enum logic [1:0] {
        CMP_OFF     = 2'd0,
        CMP_ON      = 2'd1,
        CMP_LOCKOUT = 2'd2
    } cmp_state_t;

    // Capacity code 0..3 maps to 25/50/75/100; the product never exceeds 8 bits.
    function automatic logic [7:0] cap_from_code(input logic [1:0] code);
        return ({6'd0, code} + 8'd1) * CAP_UNIT;
    endfunction

endpackage

// File: rtl/fridge_zone.sv
// One compartment: setpoint and capacity storage, cooling hysteresis flag and
// door-open timeout counter.
module fridge_zone #(
    parameter int TEMP_W       = 5,
    parameter int RESET_TEMP   = 4,
    parameter int HYST         = 2,
    parameter int DOOR_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwr,
    input  logic              wr_temp,
    input  logic              wr_cap,
    input  logic [TEMP_W-1:0] wr_data,
    input  logic [TEMP_W-1:0] temp_meas,
    input  logic              door_open,
    output logic [TEMP_W-1:0] set_temp,
    output logic [7:0]        capacity,
    output logic              cool_req,
    output logic              door_alarm
);
    import fridge_pkg::*;

    localparam int DW = $clog2(DOOR_TIMEOUT + 1);
    localparam logic [TEMP_W:0]   HYST_EXT  = (TEMP_W + 1)'(HYST);
    localparam logic [TEMP_W-1:0] RST_TEMP  = TEMP_W'(RESET_TEMP);
    localparam logic [DW-1:0]     DOOR_MAX  = DW'(DOOR_TIMEOUT);
    localparam logic [DW-1:0]     DOOR_ONE  = DW'(1);
    localparam logic [DW-1:0]     DOOR_ZERO = DW'(0);

    logic [TEMP_W-1:0] set_temp_r;
    logic [7:0]        capacity_r;
    logic              cool_req_r;
    logic              door_alarm_r;
    logic [DW-1:0]     door_cnt_r;

    logic [TEMP_W:0]   temp_ext_s;
    logic [TEMP_W:0]   set_ext_s;
    logic [TEMP_W:0]   on_thresh_s;
    logic              cool_next_s;
    logic [DW-1:0]     door_cnt_next_s;

    // Hysteresis decision in TEMP_W+1 bits so setpoint+HYST cannot wrap.
    always_comb begin
        temp_ext_s  = {1'b0, temp_meas};
        set_ext_s   = {1'b0, set_temp_r};
        on_thresh_s = set_ext_s + HYST_EXT;
        cool_next_s = cool_req_r;
        if (temp_ext_s >= on_thresh_s) begin
            cool_next_s = 1'b1;
        end else if (temp_ext_s <= set_ext_s) begin
            cool_next_s = 1'b0;
        end else begin
            cool_next_s = cool_req_r;
        end
    end

    // Saturating door-open counter, cleared on the first closed sample.
    always_comb begin
        door_cnt_next_s = door_cnt_r;
        if (!door_open) begin
            door_cnt_next_s = DOOR_ZERO;
        end else if (door_cnt_r == DOOR_MAX) begin
            door_cnt_next_s = door_cnt_r;
        end else begin
            door_cnt_next_s = door_cnt_r + DOOR_ONE;
        end
    end

    // Configuration storage survives soft-off; only reset reloads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_temp_r <= RST_TEMP;
            capacity_r <= 8'd0;
        end else begin
            if (wr_temp) begin
                set_temp_r <= wr_data;
            end else begin
                set_temp_r <= set_temp_r;
            end
            if (wr_cap) begin
                capacity_r <= cap_from_code(wr_data[1:0]);
            end else begin
                capacity_r <= capacity_r;
            end
        end
    end

    // Demand and alarm state, flushed while power is off.
    always_ff @(posedge clk) begin
        if (rst || !pwr) begin
            cool_req_r   <= 1'b0;
            door_cnt_r   <= DOOR_ZERO;
            door_alarm_r <= 1'b0;
        end else begin
            cool_req_r   <= cool_next_s;
            door_cnt_r   <= door_cnt_next_s;
            door_alarm_r <= (door_cnt_next_s == DOOR_MAX);
        end
    end

    assign set_temp   = set_temp_r;
    assign capacity   = capacity_r;
    assign cool_req   = cool_req_r;
    assign door_alarm = door_alarm_r;

endmodule

// File: rtl/fridge_zone_ctrl.sv
// Multi-zone fridge controller: write decode, shared compressor lockout FSM,
// door alarm OR and optional ice latch (enabled by FRIDGE_ICE_MAKER_EN).
module fridge_zone_ctrl #(
    parameter int NUM_ZONES    = 2,
    parameter int TEMP_W       = 5,
    parameter int RESET_TEMP   = 4,
    parameter int HYST         = 2,
    parameter int MIN_OFF      = 8,
    parameter int DOOR_TIMEOUT = 16,
    localparam int ZW          = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pwr,
    input  logic                        wr_en,
    input  logic [1:0]                  sel_field,
    input  logic [ZW-1:0]               zone_sel,
    input  logic [TEMP_W-1:0]           wr_data,
    input  logic [NUM_ZONES*TEMP_W-1:0] temp_meas,
    input  logic [NUM_ZONES-1:0]        door_open,
    output logic [NUM_ZONES*TEMP_W-1:0] set_temp,
    output logic [NUM_ZONES*8-1:0]      capacity,
    output logic [NUM_ZONES-1:0]        cool_req,
    output logic                        compressor_on,
    output logic                        door_alarm,
    output logic                        ice_on
);
    import fridge_pkg::*;

    localparam int CNT_W = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(MIN_OFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [ZW:0]      NZ_EXT    = (ZW + 1)'(NUM_ZONES);

    logic                 wr_ok_s;
    logic                 zone_ok_s;
    logic                 is_temp_s;
    logic                 is_cap_s;
    logic [NUM_ZONES-1:0] zone_alarm_s;
    logic                 any_cool_s;

    cmp_state_t           state_r;
    cmp_state_t           state_next_s;
    logic [CNT_W-1:0]     lock_cnt_r;
    logic [CNT_W-1:0]     lock_cnt_next_s;
    logic                 compressor_on_r;

`ifdef FRIDGE_ICE_MAKER_EN
    logic                 is_ice_s;
    logic                 ice_latch_r;
    logic                 ice_latch_next_s;
    logic                 ice_on_r;
`endif

    assign wr_ok_s   = wr_en & pwr;
    assign zone_ok_s = ({1'b0, zone_sel} < NZ_EXT);

    // Field decode; the reserved code and a disabled ice field do nothing.
    always_comb begin
        is_temp_s = 1'b0;
        is_cap_s  = 1'b0;
`ifdef FRIDGE_ICE_MAKER_EN
        is_ice_s  = 1'b0;
`endif
        case (sel_field)
            FIELD_TEMP: is_temp_s = 1'b1;
            FIELD_CAP:  is_cap_s  = 1'b1;
            FIELD_ICE: begin
`ifdef FRIDGE_ICE_MAKER_EN
                is_ice_s = 1'b1;
`endif
            end
            FIELD_RSVD: is_temp_s = 1'b0;
            default:    is_temp_s = 1'b0;
        endcase
    end

    genvar z;
    for (z = 0; z < NUM_ZONES; z++) begin : g_zone
        logic zone_hit_s;
        assign zone_hit_s = wr_ok_s & zone_ok_s & (zone_sel == ZW'(z));

        fridge_zone #(
            .TEMP_W       (TEMP_W),
            .RESET_TEMP   (RESET_TEMP),
            .HYST         (HYST),
            .DOOR_TIMEOUT (DOOR_TIMEOUT)
        ) u_zone (
            .clk        (clk),
            .rst        (rst),
            .pwr        (pwr),
            .wr_temp    (zone_hit_s & is_temp_s),
            .wr_cap     (zone_hit_s & is_cap_s),
            .wr_data    (wr_data),
            .temp_meas  (temp_meas[z*TEMP_W +: TEMP_W]),
            .door_open  (door_open[z]),
            .set_temp   (set_temp[z*TEMP_W +: TEMP_W]),
            .capacity   (capacity[z*8 +: 8]),
            .cool_req   (cool_req[z]),
            .door_alarm (zone_alarm_s[z])
        );
    end

    assign any_cool_s = |cool_req;
    assign door_alarm = |zone_alarm_s;

    // Compressor next state; lockout ignores demand until its counter expires.
    always_comb begin
        state_next_s    = state_r;
        lock_cnt_next_s = lock_cnt_r;
        if (!pwr) begin
            state_next_s    = CMP_OFF;
            lock_cnt_next_s = CNT_ZERO;
        end else begin
            case (state_r)
                CMP_OFF: begin
                    if (any_cool_s) begin
                        state_next_s = CMP_ON;
                    end else begin
                        state_next_s = CMP_OFF;
                    end
                end
                CMP_ON: begin
                    if (!any_cool_s) begin
                        state_next_s    = CMP_LOCKOUT;
                        lock_cnt_next_s = LOCK_LOAD;
                    end else begin
                        state_next_s = CMP_ON;
                    end
                end
                CMP_LOCKOUT: begin
                    if (lock_cnt_r == CNT_ZERO) begin
                        state_next_s = CMP_OFF;
                    end else begin
                        lock_cnt_next_s = lock_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_next_s    = CMP_OFF;
                    lock_cnt_next_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Compressor state, lockout counter and registered drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= CMP_OFF;
            lock_cnt_r      <= CNT_ZERO;
            compressor_on_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            lock_cnt_r      <= lock_cnt_next_s;
            compressor_on_r <= (state_next_s == CMP_ON);
        end
    end

    assign compressor_on = compressor_on_r;

`ifdef FRIDGE_ICE_MAKER_EN
    // Ice write is global, so zone_sel plays no part.
    always_comb begin
        ice_latch_next_s = ice_latch_r;
        if (wr_ok_s && is_ice_s) begin
            ice_latch_next_s = wr_data[0];
        end else begin
            ice_latch_next_s = ice_latch_r;
        end
    end

    // Latch is kept across soft-off; only the drive is masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            ice_latch_r <= 1'b0;
            ice_on_r    <= 1'b0;
        end else begin
            ice_latch_r <= ice_latch_next_s;
            if (pwr) begin
                ice_on_r <= ice_latch_next_s;
            end else begin
                ice_on_r <= 1'b0;
            end
        end
    end

    assign ice_on = ice_on_r;
`else
    assign ice_on = 1'b0;
`endif

endmodule
